// File: rtl/monolith_sponge_ctrl.sv
// Sponge controller in front of the Monolith permutation core: absorbs Mersenne-31
// words into the rate, pads, sequences permutations and presents the digest.
module monolith_sponge_ctrl #(
  parameter int unsigned WORD_WIDTH  = 31,
  parameter int unsigned STATE_SIZE  = 16,
  parameter int unsigned RATE        = 8,
  parameter int unsigned DIGEST_SIZE = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [WORD_WIDTH-1:0]                    in_data,
  input  logic                                     in_last,
  output logic                                     hash_reset,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]    hash_state_in,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]    hash_state_out,
  input  logic                                     hash_valid,
  output logic                                     digest_valid,
  input  logic                                     digest_ready,
  output logic [DIGEST_SIZE-1:0][WORD_WIDTH-1:0]   digest
);

  localparam int unsigned POS_W = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [WORD_WIDTH-1:0] MODULUS  = {WORD_WIDTH{1'b1}};
  localparam logic [POS_W-1:0]      LAST_POS = POS_W'(RATE - 1);

  localparam logic [1:0] ST_ABSORB  = 2'd0;
  localparam logic [1:0] ST_PAD     = 2'd1;
  localparam logic [1:0] ST_PERMUTE = 2'd2;
  localparam logic [1:0] ST_SQUEEZE = 2'd3;

  logic [1:0]                              fsm_q, fsm_n;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]   state_q, state_n;
  logic [POS_W-1:0]                        pos_q, pos_n;
  logic                                    final_q, final_n;
  logic                                    pad_pending_q, pad_pending_n;
  logic                                    perm_first_q, perm_first_n;

  // Modular add; an input equal to p is the field's zero.
  function automatic logic [WORD_WIDTH-1:0] field_add(input logic [WORD_WIDTH-1:0] a,
                                                      input logic [WORD_WIDTH-1:0] b);
    logic [WORD_WIDTH-1:0] b_red;
    logic [WORD_WIDTH:0]   sum;
    b_red = (b == MODULUS) ? '0 : b;
    sum   = {1'b0, a} + {1'b0, b_red};
    if (sum >= {1'b0, MODULUS}) sum = sum - {1'b0, MODULUS};
    return sum[WORD_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q         <= ST_ABSORB;
      state_q       <= '0;
      pos_q         <= '0;
      final_q       <= 1'b0;
      pad_pending_q <= 1'b0;
      perm_first_q  <= 1'b0;
    end else begin
      fsm_q         <= fsm_n;
      state_q       <= state_n;
      pos_q         <= pos_n;
      final_q       <= final_n;
      pad_pending_q <= pad_pending_n;
      perm_first_q  <= perm_first_n;
    end
  end

  always_comb begin
    fsm_n         = fsm_q;
    state_n       = state_q;
    pos_n         = pos_q;
    final_n       = final_q;
    pad_pending_n = pad_pending_q;
    perm_first_n  = 1'b0;
    case (fsm_q)
      ST_ABSORB: begin
        if (in_valid) begin
          state_n[pos_q] = field_add(state_q[pos_q], in_data);
          if (pos_q == LAST_POS) begin
            pos_n        = '0;
            fsm_n        = ST_PERMUTE;
            perm_first_n = 1'b1;
            if (in_last) pad_pending_n = 1'b1;
          end else begin
            pos_n = pos_q + POS_W'(1);
            if (in_last) fsm_n = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        state_n[pos_q] = field_add(state_q[pos_q], WORD_WIDTH'(1));
        final_n        = 1'b1;
        pad_pending_n  = 1'b0;
        fsm_n          = ST_PERMUTE;
        perm_first_n   = 1'b1;
      end
      ST_PERMUTE: begin
        // The core is just leaving reset in the first cycle, so its valid is not trusted yet.
        if (hash_valid && !perm_first_q) begin
          state_n = hash_state_out;
          if (final_q) begin
            fsm_n = ST_SQUEEZE;
          end else if (pad_pending_q) begin
            fsm_n = ST_PAD;
            pos_n = '0;
          end else begin
            fsm_n = ST_ABSORB;
          end
        end
      end
      ST_SQUEEZE: begin
        if (digest_ready) begin
          state_n       = '0;
          pos_n         = '0;
          final_n       = 1'b0;
          pad_pending_n = 1'b0;
          fsm_n         = ST_ABSORB;
        end
      end
      default: fsm_n = ST_ABSORB;
    endcase
  end

  assign in_ready      = (fsm_q == ST_ABSORB) && !reset;
  assign hash_reset    = (fsm_q != ST_PERMUTE) || reset;
  assign digest_valid  = (fsm_q == ST_SQUEEZE);
  assign hash_state_in = state_q;
  assign digest        = state_q[DIGEST_SIZE-1:0];

endmodule

// File: tb/tb_monolith_sponge_ctrl.sv
// Bench for monolith_sponge_ctrl: stub core (latency 5, word+1 mod p) and a
// message-level sponge model predicting every permutation input and digest.
module tb_monolith_sponge_ctrl;

  localparam int unsigned WW = 31;
  localparam int unsigned SS = 16;
  localparam int unsigned RT = 8;
  localparam int unsigned DS = 8;
  localparam longint      PMOD = 64'h7FFF_FFFF;

  typedef logic [WW-1:0]          word_t;
  typedef logic [SS-1:0][WW-1:0]  vec_t;
  typedef logic [DS-1:0][WW-1:0]  dig_t;

  logic  clk, reset, in_valid, in_ready, in_last, hash_reset, hash_valid;
  logic  digest_valid, digest_ready;
  word_t in_data;
  vec_t  hash_state_in, hash_state_out;
  dig_t  digest;

  monolith_sponge_ctrl #(.WORD_WIDTH(WW), .STATE_SIZE(SS), .RATE(RT), .DIGEST_SIZE(DS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .hash_reset(hash_reset), .hash_state_in(hash_state_in),
    .hash_state_out(hash_state_out), .hash_valid(hash_valid), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .digest(digest));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int windows = 0;
  vec_t exp_perm[$];
  dig_t exp_dig[$];

  function automatic word_t madd(input word_t a, input word_t b);
    longint s;
    s = longint'(a) + ((b == word_t'(PMOD)) ? 64'd0 : longint'(b));
    if (s >= PMOD) s = s - PMOD;
    return word_t'(s);
  endfunction

  function automatic vec_t stub_perm(input vec_t v);
    vec_t r;
    for (int i = 0; i < SS; i++) r[i] = madd(v[i], word_t'(1));
    return r;
  endfunction

  // Stub core: valid 5 cycles after its reset drops; output is state_in word-wise +1.
  logic [3:0] stub_cnt;
  always @(posedge clk) begin
    if (hash_reset) begin
      stub_cnt   <= 4'd0;
      hash_valid <= 1'b0;
    end else begin
      if (stub_cnt != 4'd15) stub_cnt <= stub_cnt + 4'd1;
      hash_valid <= (stub_cnt == 4'd4);
    end
  end
  assign hash_state_out = stub_perm(hash_state_in);

  logic rdy_force, rdy_val, rdy_rnd;
  assign digest_ready = rdy_force ? rdy_val : rdy_rnd;
  initial begin
    rdy_rnd = 1'b0;
    forever begin
      @(posedge clk);
      #1 rdy_rnd = 1'($urandom_range(0, 1));
    end
  end

  // Sponge over whole blocks: pad 1 after the last word, one permutation per full block.
  function automatic void model_run(input word_t w[$], output vec_t perms[$], output dig_t dg);
    vec_t st;
    int   pos;
    st = '0;
    pos = 0;
    perms.delete();
    foreach (w[i]) begin
      st[pos] = madd(st[pos], w[i]);
      pos++;
      if (pos == RT) begin
        perms.push_back(st);
        st = stub_perm(st);
        pos = 0;
      end
    end
    st[pos] = madd(st[pos], word_t'(1));
    perms.push_back(st);
    st = stub_perm(st);
    dg = st[DS-1:0];
  endfunction

  function automatic vec_t mkvec(input int unsigned a[$]);
    vec_t v;
    v = '0;
    foreach (a[i]) v[i] = word_t'(a[i]);
    return v;
  endfunction

  function automatic void mkmsg(input int unsigned a[$], output word_t m[$]);
    m.delete();
    foreach (a[i]) m.push_back(word_t'(a[i]));
  endfunction

  task automatic chkv(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chkv(name, 512'(act), 512'(req));
  endtask

  task automatic chki(input string name, input int act, input int req);
    chkv(name, 512'(act), 512'(req));
  endtask

  // Per-cycle compare against the model queues.
  logic prev_hr = 1'b1;
  vec_t perm_snap;
  always @(negedge clk) begin
    if (reset) begin
      chk1("rst_hash_reset", hash_reset, 1'b1);
      chk1("rst_digest_valid", digest_valid, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b0);
      prev_hr = 1'b1;
    end else begin
      if (digest_valid) begin
        chk1("squeeze_in_ready", in_ready, 1'b0);
        chk1("squeeze_hash_reset", hash_reset, 1'b1);
      end
      if (!hash_reset) chk1("permute_in_ready", in_ready, 1'b0);
      if (prev_hr && !hash_reset) begin
        windows++;
        if (exp_perm.size() == 0) chk1("perm_unexpected", 1'b1, 1'b0);
        else chkv("perm_in", 512'(hash_state_in), 512'(exp_perm.pop_front()));
        perm_snap = hash_state_in;
      end else if (!hash_reset) begin
        chkv("perm_stable", 512'(hash_state_in), 512'(perm_snap));
      end
      if (digest_valid) begin
        if (exp_dig.size() == 0) chk1("digest_unexpected", 1'b1, 1'b0);
        else begin
          chkv("digest", 512'(digest), 512'(exp_dig[0]));
          if (digest_ready) void'(exp_dig.pop_front());
        end
      end
      prev_hr = hash_reset;
    end
  end

  task automatic send_msg(input word_t w[$], input int mode);
    vec_t perms[$];
    dig_t dg;
    bit   gap, ok, was;
    vec_t snap;
    model_run(w, perms, dg);
    foreach (perms[i]) exp_perm.push_back(perms[i]);
    exp_dig.push_back(dg);
    foreach (w[i]) begin
      gap = (mode == 1) ? (i > 0) : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (gap) begin
        was = in_ready;
        snap = hash_state_in;
        in_valid = 1'b0;
        in_data = word_t'($urandom);
        @(posedge clk);
        #1;
        if (was && in_ready) chkv("bubble_hold", 512'(hash_state_in), 512'(snap));
      end
      in_valid = 1'b1;
      in_data = w[i];
      in_last = (i == w.size() - 1);
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (in_ready) begin
          @(posedge clk);
          #1;
          ok = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      if (!ok) chk1("accept_timeout", 1'b0, 1'b1);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (exp_perm.size() == 0 && exp_dig.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) chk1("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic measure(output int lat, output dig_t d);
    lat = -1;
    d = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (digest_valid) begin
        lat = k;
        d = digest;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    word_t m[$];
    vec_t  perms[$];
    vec_t  v;
    dig_t  dg, d_exp, d_held;
    int    lat, w0;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    rdy_force = 1'b1; rdy_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_in_ready", in_ready, 1'b0);
    chk1("reset_hash_reset", hash_reset, 1'b1);
    chk1("reset_digest_valid", digest_valid, 1'b0);
    chkv("reset_state", 512'(hash_state_in), 512'(0));
    reset = 1'b0;
    #1;
    chk1("post_reset_in_ready", in_ready, 1'b1);

    // Hand-computed pins on the model itself.
    mkmsg('{5, 6, 7}, m);
    model_run(m, perms, dg);
    chkv("model_t1_perm", 512'(perms[0]), 512'(mkvec('{5, 6, 7, 1})));
    v = mkvec('{6, 7, 8, 2, 1, 1, 1, 1});
    d_exp = v[DS-1:0];
    chkv("model_t1_digest", 512'(dg), 512'(d_exp));
    mkmsg('{1, 2, 3, 4, 5, 6, 7, 8}, m);
    model_run(m, perms, dg);
    chki("model_t2_nperm", perms.size(), 2);
    chkv("model_t2_perm1", 512'(perms[1]),
         512'(mkvec('{3, 3, 4, 5, 6, 7, 8, 9, 1, 1, 1, 1, 1, 1, 1, 1})));
    mkmsg('{32'h7FFFFFFD, 32'h7FFFFFFF, 1, 2, 3, 4, 5, 6, 5}, m);
    model_run(m, perms, dg);
    chkv("model_t3_p_is_zero", 512'(perms[0][1]), 512'(0));
    chkv("model_t3_wrap", 512'(perms[1][0]), 512'(4));

    // Test 1 + 4: latency, literal digest, stall with ready low, then release.
    mkmsg('{5, 6, 7}, m);
    send_msg(m, 0);
    measure(lat, d_held);
    chki("t1_latency", lat, 7);
    chkv("t1_digest_literal", 512'(d_held), 512'(d_exp));
    repeat (10) begin
      @(posedge clk);
      #1;
      chk1("t4_hold_valid", digest_valid, 1'b1);
      chk1("t4_hold_in_ready", in_ready, 1'b0);
      chkv("t4_hold_digest", 512'(digest), 512'(d_held));
    end
    rdy_val = 1'b1;
    @(posedge clk);
    #1;
    rdy_val = 1'b0;
    chk1("t4_release_in_ready", in_ready, 1'b1);
    chk1("t4_release_valid", digest_valid, 1'b0);
    chkv("t4_release_state", 512'(hash_state_in), 512'(0));

    // Test 2: exactly-full final block needs two permutations.
    rdy_val = 1'b1;
    w0 = windows;
    mkmsg('{1, 2, 3, 4, 5, 6, 7, 8}, m);
    send_msg(m, 0);
    wait_idle();
    chki("t2_windows", windows - w0, 2);

    // Test 3: p reduces to zero; wraparound in the second block.
    mkmsg('{32'h7FFFFFFD, 32'h7FFFFFFF, 1, 2, 3, 4, 5, 6, 5}, m);
    send_msg(m, 0);
    wait_idle();

    // Test 5: reset a few cycles into the permutation.
    rdy_val = 1'b0;
    mkmsg('{5, 6, 7}, m);
    send_msg(m, 0);
    repeat (4) @(posedge clk);
    #1;
    chk1("t5_in_permute", hash_reset, 1'b0);
    reset = 1'b1;
    #1;
    chk1("t5_hash_reset", hash_reset, 1'b1);
    chk1("t5_digest_valid", digest_valid, 1'b0);
    chkv("t5_state", 512'(hash_state_in), 512'(0));
    exp_perm.delete();
    exp_dig.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    send_msg(m, 0);
    measure(lat, dg);
    chki("t5_latency", lat, 7);
    chkv("t5_digest_literal", 512'(dg), 512'(d_exp));
    rdy_val = 1'b1;
    wait_idle();

    // Test 6: in_valid toggling, 9 words, random digest_ready.
    rdy_force = 1'b0;
    m.delete();
    for (int i = 0; i < 9; i++) m.push_back(word_t'($urandom));
    send_msg(m, 1);
    wait_idle();

    // Random back-to-back messages with random gaps and edge-valued words.
    for (int n = 0; n < 25; n++) begin
      int len;
      int r;
      len = $urandom_range(1, 20);
      m.delete();
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        m.push_back(r == 0 ? word_t'(PMOD) : r == 1 ? word_t'(PMOD - 1) :
                    r == 2 ? word_t'(0) : word_t'($urandom));
      end
      send_msg(m, 2);
    end
    wait_idle();
    chki("final_queues_empty", exp_perm.size() + exp_dig.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
